switch_debounce: RTL
====================

# switch_debounce

Input-conditioning stage for the two-bit logic-gate datapath: it synchronises two raw, bouncing slide-switch inputs and qualifies each bit independently with a stability counter. It drives a clean two-bit vector straight into the gate block's two-bit input, so the AND/OR/XOR results never see metastable or bouncing values. It also flags when its output is trustworthy after reset, and can optionally pulse on every qualified change.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised bit must differ from the current output before the output takes the new value; legal range 1 to 2^CNT_W − 1.
- CNT_W, 5: width of each per-bit stability counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  [0:1]  asynchronous raw switch levels.
- sw_out  output  [0:1]  debounced levels; feeds the gate block input directly, same bit order.
- sw_valid  output  1  high once sw_out reflects inputs held stable since reset.
- chg_pulse  output  [0:1]  per-bit one-cycle change strobe; present only with CHG_PULSE_EN.

## Operation
- Each sw_raw bit passes through a two-flop synchroniser (sync0 → sync1); only sync1 is used downstream.
- Per bit, two states:
  - STABLE: counter = 0 and sync1 == sw_out.
  - COUNTING: sync1 != sw_out; counter increments once per cycle.
- Transitions, per bit:
  - In COUNTING, if sync1 returns to equal sw_out (bounce), the counter clears and the bit returns to STABLE.
  - In COUNTING, when counter == DEBOUNCE_CYCLES−1 and sync1 still differs, on that edge sw_out <= sync1, the counter clears and the bit goes to STABLE.
- The two bits are fully independent and may update on the same edge.
- The counter never exceeds DEBOUNCE_CYCLES−1, so no wrap-around is possible.
- sw_valid: a settle counter starts after reset. sw_valid rises DEBOUNCE_CYCLES+1 edges after the first edge with rst low, then stays high until the next reset.
- Reset values:
  - sync0, sync1, sw_out: 2'b00
  - all counters: 0
  - sw_valid: 0
  - chg_pulse: 2'b00
- Reset mid-count discards all progress; there is no memory of pre-reset input history.

## Timing
- Let k be the first edge at which a new sw_raw level is sampled, with the level held afterwards. sw_out updates on edge k+DEBOUNCE_CYCLES+1. Breakdown: 2 synchroniser edges, then DEBOUNCE_CYCLES−1 counting edges, with the update on the final edge.
- A level held for fewer than DEBOUNCE_CYCLES cycles at sync1 produces no output change.
- rst has priority over all other activity on the same edge.
- sw_out is registered; there is no combinational path from sw_raw to any output.
- sw_valid latency from reset release matches the single-change latency: edge r+DEBOUNCE_CYCLES+1, where r is the first edge with rst low.

## Configuration
- Macro: CHG_PULSE_EN.
- Defined:
  - chg_pulse[i] is registered high for exactly the one cycle in which sw_out[i] first shows a new value, then low.
  - Bits are independent; chg_pulse = 2'b11 when both bits update on the same edge.
  - chg_pulse is held low while sw_valid = 0, which suppresses the post-reset settle update.
- Undefined: the chg_pulse port and its logic are absent; all other behaviour is identical.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, CNT_W = 3.

- Reset with sw_raw = 2'b11, release at edge r:
  - During reset: sw_out = 00, sw_valid = 0.
  - At edge r+5: sw_out = 11, sw_valid = 1; with CHG_PULSE_EN, chg_pulse stays 00.
- Clean change on bit 0, 0→1, first sampled at edge k with sw_valid = 1:
  - sw_out[0] = 1 after edge k+5, not before.
  - chg_pulse = 2'b10 for exactly one cycle; sw_out[1] is unchanged.
- Bounce on bit 1, sampled 1,1,0,1,0,1,1,1…, settling at edge k:
  - No sw_out change during the bounce.
  - sw_out[1] = 1 after edge k+5, with a single chg_pulse[1].
- Glitch: sw_raw = 01 held 3 cycles, then back to 00 → sw_out stays 00 and chg_pulse stays 00 throughout.
- Simultaneous change 00→11 sampled at edge k → both bits update on edge k+5; chg_pulse = 11 for one cycle.
- Reset mid-count: bit 0 counter at 2, assert rst for one cycle:
  - Next cycle: sw_out = 00, sw_valid = 0, chg_pulse = 00.
  - A fresh full-latency settle is required before sw_valid returns high.

Source files
------------

// File: rtl/switch_debounce.sv
// Two-bit slide-switch conditioner: 2-flop synchroniser plus independent per-bit stability counters.
// Latency: a held input change reaches sw_out DEBOUNCE_CYCLES+1 edges after it is first sampled.
// Backpressure: none, free-running every cycle. Optional macro CHG_PULSE_EN adds the chg_pulse strobe port.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:1] sw_raw,
  output logic [0:1] sw_out,
  output logic       sw_valid
`ifdef CHG_PULSE_EN
  ,
  output logic [0:1] chg_pulse
`endif
);

  // Last counter value before a still-differing bit is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Settle counter needs one extra bit: its terminal value DEBOUNCE_CYCLES+1 may equal 2^CNT_W.
  localparam logic [CNT_W:0]   SETTLE_LAST = (CNT_W + 1)'(DEBOUNCE_CYCLES + 1);

  logic [0:1]            sync0;
  logic [0:1]            sync1;
  logic [0:1][CNT_W-1:0] cnt;
  logic [0:1][CNT_W-1:0] cnt_nxt;
  logic [0:1]            out_nxt;
  logic [CNT_W:0]        settle_cnt;

  // Two-flop synchroniser; only sync1 feeds the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= sw_raw;
      sync1 <= sync0;
    end
  end

  // Per-bit next state: count while sync1 differs from sw_out, accept on the last count, clear on bounce.
  always_comb begin
    out_nxt = sw_out;
    cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync1[i] != sw_out[i]) begin
        if (cnt[i] == CNT_LAST) begin
          out_nxt[i] = sync1[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state register: output levels and per-bit stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_out <= '0;
      cnt    <= '0;
    end else begin
      sw_out <= out_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Post-reset settle timer; sw_valid rises once a full debounce window has elapsed, then sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sw_valid   <= 1'b0;
    end else if (!sw_valid) begin
      if (settle_cnt == SETTLE_LAST) begin
        sw_valid <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + (CNT_W + 1)'(1);
      end
    end
  end

`ifdef CHG_PULSE_EN
  // Change strobe aligned with the sw_out update; masked until valid so the settle update is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_pulse <= '0;
    end else begin
      chg_pulse <= (out_nxt ^ sw_out) & {2{sw_valid}};
    end
  end
`endif

endmodule
